// File: rtl/md_arb_pkg.sv
// Shared definitions for the multiply/divide arbiter: FSM state encoding,
// ALU opcodes that select the unit's operation, and default widths.
package md_arb_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned OP_W           = 5;

  localparam logic [OP_W-1:0] ALU_MULT = 5'b00110;
  localparam logic [OP_W-1:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_A = 2'd1,
    ST_RUN_B = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  // Only ALU_DIV selects divide; every other opcode is issued as a multiply.
  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return op == ALU_DIV;
  endfunction

endpackage

// File: rtl/md_arbiter_if.sv
// Bus between the arbiter and the shared multiply/divide unit.
//   md_start/md_is_div/md_a/md_b : command, valid on the md_start pulse
//   md_abort                     : resets the unit's sequencer
//   md_ready/md_result/md_exc    : one-cycle response from the unit
interface md_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              md_start;
  logic              md_is_div;
  logic [DATA_W-1:0] md_a;
  logic [DATA_W-1:0] md_b;
  logic              md_abort;
  logic              md_ready;
  logic [DATA_W-1:0] md_result;
  logic              md_exc;

  modport master (
    output md_start, md_is_div, md_a, md_b, md_abort,
    input  md_ready, md_result, md_exc
  );

  modport slave (
    input  md_start, md_is_div, md_a, md_b, md_abort,
    output md_ready, md_result, md_exc
  );
endinterface

// File: rtl/md_watchdog.sv
// Cycle counter guarding an operation in flight on the multiply/divide unit.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart counting (operation started)
//   run        : an operation is outstanding
//   expire_c   : combinational terminal-count flag, CYCLES cycles after clear
module md_watchdog #(
  parameter int unsigned CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Count stops at terminal value; the next start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expire_c) begin
      count <= count + CNT_W'(1);
    end
  end

  // The first run cycle sees count 0, so CYCLES-1 is the CYCLES-th cycle.
  assign expire_c = run && (count == CNT_W'(CYCLES - 1));

endmodule

// File: rtl/md_arbiter.sv
// Arbitrates the shared multiply/divide unit between issue slots A (older)
// and B (younger); stalls the pipeline until both results are captured and
// then releases it for a single cycle with done=1.
//   clock, reset_n          : clock, async active-low reset
//   flush                   : kill the packet, abort the operation in flight
//   req_x, op_x, a_in_x, b_in_x : per-slot request, opcode, operands
//   md                      : master side of the unit bus (md_arbiter_if)
//   stall                   : combinational pipeline freeze
//   result_x, exc_x, done   : registered results, exception flags, release
// Optional: define MD_WATCHDOG_EN to abort operations that never complete
// within WATCHDOG_CYCLES cycles (slot completes with result 0, exception 1).
module md_arbiter
  import md_arb_pkg::*;
#(
  parameter int unsigned DATA_W          = DATA_W_DEFAULT,
  parameter int unsigned WATCHDOG_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  input  logic [DATA_W-1:0] a_in_a,
  input  logic [DATA_W-1:0] b_in_a,
  input  logic [DATA_W-1:0] a_in_b,
  input  logic [DATA_W-1:0] b_in_b,
  md_arbiter_if.master      md,
  output logic              stall,
  output logic [DATA_W-1:0] result_a,
  output logic [DATA_W-1:0] result_b,
  output logic              exc_a,
  output logic              exc_b,
  output logic              done
);

  md_state_e         state, state_nxt;
  logic              pend_b;
  logic              load_pend;
  logic              cap_a, cap_b;
  logic [DATA_W-1:0] cap_result;
  logic              cap_exc;
  logic              start_c, is_div_c, abort_c;
  logic [DATA_W-1:0] opnd_a_c, opnd_b_c;
  logic              running;
  logic              wd_expire;

  assign running = (state == ST_RUN_A) || (state == ST_RUN_B);

`ifdef MD_WATCHDOG_EN
  md_watchdog #(
    .CYCLES (WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk      (clock),
    .rst_n    (reset_n),
    .clear    (start_c),
    .run      (running),
    .expire_c (wd_expire)
  );
`else
  // Without the watchdog the limit has no effect and operations never time out.
  assign wd_expire = 1'b0 & (WATCHDOG_CYCLES != 0);
`endif

  // A real ready wins over a coincident timeout; a timeout reads as 0 / exception.
  assign cap_result = md.md_ready ? md.md_result : '0;
  assign cap_exc    = md.md_ready ? md.md_exc    : 1'b1;

  // Next-state and unit command decode.
  always_comb begin
    state_nxt = state;
    load_pend = 1'b0;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    start_c   = 1'b0;
    is_div_c  = 1'b0;
    abort_c   = 1'b0;
    opnd_a_c  = '0;
    opnd_b_c  = '0;

    unique case (state)
      ST_IDLE: begin
        if (!flush && req_a) begin
          start_c   = 1'b1;
          is_div_c  = op_is_div(op_a);
          opnd_a_c  = a_in_a;
          opnd_b_c  = b_in_a;
          load_pend = 1'b1;
          state_nxt = ST_RUN_A;
        end else if (!flush && req_b) begin
          start_c   = 1'b1;
          is_div_c  = op_is_div(op_b);
          opnd_a_c  = a_in_b;
          opnd_b_c  = b_in_b;
          state_nxt = ST_RUN_B;
        end
      end

      ST_RUN_A: begin
        if (flush) begin
          abort_c   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (md.md_ready || wd_expire) begin
          abort_c = !md.md_ready;
          cap_a   = 1'b1;
          // B launches in the same cycle A completes: no bubble.
          if (pend_b) begin
            start_c   = 1'b1;
            is_div_c  = op_is_div(op_b);
            opnd_a_c  = a_in_b;
            opnd_b_c  = b_in_b;
            state_nxt = ST_RUN_B;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end

      ST_RUN_B: begin
        if (flush) begin
          abort_c   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (md.md_ready || wd_expire) begin
          abort_c   = !md.md_ready;
          cap_b     = 1'b1;
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pending-B flag and result capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pend_b   <= 1'b0;
      result_a <= '0;
      result_b <= '0;
      exc_a    <= 1'b0;
      exc_b    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_pend) begin
        pend_b <= req_b;
      end
      if (cap_a) begin
        result_a <= cap_result;
        exc_a    <= cap_exc;
      end
      if (cap_b) begin
        result_b <= cap_result;
        exc_b    <= cap_exc;
      end
    end
  end

  assign md.md_start  = start_c;
  assign md.md_is_div = is_div_c;
  assign md.md_a      = opnd_a_c;
  assign md.md_b      = opnd_b_c;
  assign md.md_abort  = abort_c;

  assign stall = running || ((state == ST_IDLE) && (req_a || req_b) && !flush);
  assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_md_arbiter.sv
// Self-checking bench for md_arbiter: a behavioural multiply/divide unit
// answers md_start after a programmable latency; expected unit commands are
// queued by each scenario and compared when the arbiter issues them.
module tb_md_arbiter;
  import md_arb_pkg::*;

  localparam int unsigned DW = 32;

  typedef struct {
    logic          is_div;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } start_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          req_a, req_b;
  logic [4:0]    op_a, op_b;
  logic [DW-1:0] a_in_a, b_in_a, a_in_b, b_in_b;
  logic          stall;
  logic [DW-1:0] result_a, result_b;
  logic          exc_a, exc_b, done;

  int checks = 0;
  int passes = 0;

  start_t exp_q[$];

  int            unit_lat  = 3;
  bit            unit_hang = 1'b0;
  bit            u_busy    = 1'b0;
  int            u_cnt     = 0;
  logic [DW-1:0] u_res;
  logic          u_exc;

  md_arbiter_if #(.DATA_W(DW)) mif ();

  md_arbiter #(
    .DATA_W          (DW),
    .WATCHDOG_CYCLES (8)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .req_a    (req_a),
    .req_b    (req_b),
    .op_a     (op_a),
    .op_b     (op_b),
    .a_in_a   (a_in_a),
    .b_in_a   (b_in_a),
    .a_in_b   (a_in_b),
    .b_in_b   (b_in_b),
    .md       (mif),
    .stall    (stall),
    .result_a (result_a),
    .result_b (result_b),
    .exc_a    (exc_a),
    .exc_b    (exc_b),
    .done     (done)
  );

  always #5 clock = ~clock;

  // Unit model plus command scoreboard: responses driven after posedge,
  // commands sampled on negedge.
  initial begin
    start_t e;
    mif.md_ready  = 1'b0;
    mif.md_result = '0;
    mif.md_exc    = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      mif.md_ready  = 1'b0;
      mif.md_result = '0;
      mif.md_exc    = 1'b0;
      if (u_busy && !unit_hang) begin
        u_cnt = u_cnt - 1;
        if (u_cnt == 0) begin
          mif.md_ready  = 1'b1;
          mif.md_result = u_res;
          mif.md_exc    = u_exc;
          u_busy        = 1'b0;
        end
      end
      @(negedge clock);
      if (mif.md_abort) u_busy = 1'b0;
      if (mif.md_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL start_unexpected: got is_div=%0b a=%0d b=%0d, required no md_start",
                   mif.md_is_div, mif.md_a, mif.md_b);
        end else begin
          e = exp_q.pop_front();
          if ({mif.md_is_div, mif.md_a, mif.md_b} !== {e.is_div, e.a, e.b})
            $display("FAIL start_cmd: got is_div=%0b a=%0d b=%0d, required is_div=%0b a=%0d b=%0d",
                     mif.md_is_div, mif.md_a, mif.md_b, e.is_div, e.a, e.b);
          else
            passes++;
        end
        u_busy = 1'b1;
        u_cnt  = unit_lat;
        if (!mif.md_is_div) begin
          u_res = mif.md_a * mif.md_b;
          u_exc = 1'b0;
        end else if (mif.md_b == '0) begin
          u_res = '0;
          u_exc = 1'b1;
        end else begin
          u_res = mif.md_a / mif.md_b;
          u_exc = 1'b0;
        end
      end
    end
  end

  task automatic idle_inputs();
    flush  = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    op_a   = ALU_MULT;
    op_b   = ALU_MULT;
    a_in_a = '0;
    b_in_a = '0;
    a_in_b = '0;
    b_in_b = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clock);
    checks++;
    if ({stall, done, exc_a, exc_b, mif.md_start, mif.md_abort} !== 6'b0)
      $display("FAIL reset_ctrl: got stall/done/exc_a/exc_b/start/abort=%b, required 000000",
               {stall, done, exc_a, exc_b, mif.md_start, mif.md_abort});
    else passes++;
    checks++;
    if (result_a !== '0 || result_b !== '0)
      $display("FAIL reset_results: got %0d/%0d, required 0/0", result_a, result_b);
    else passes++;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_a_only();
    int stall_cnt = 0;
    bit seen = 1'b0;
    unit_lat = 3;
    exp_q.push_back('{1'b0, 32'd6, 32'd7});
    @(posedge clock); #1;
    req_a = 1'b1; op_a = ALU_MULT; a_in_a = 32'd6; b_in_a = 32'd7;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (stall) stall_cnt++;
      if (done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || stall_cnt != 4)
      $display("FAIL a_only_stall: got done=%0b stall_cycles=%0d, required done=1 stall_cycles=4", seen, stall_cnt);
    else passes++;
    checks++;
    if (result_a !== 32'd42 || exc_a !== 1'b0)
      $display("FAIL a_only_result: got %0d exc=%0b, required 42 exc=0", result_a, exc_a);
    else passes++;
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || stall !== 1'b0)
      $display("FAIL a_only_release: got done=%0b stall=%0b, required 0/0", done, stall);
    else passes++;
  endtask

  task automatic test_both();
    int stall_cnt = 0;
    bit seen = 1'b0;
    bit coinc = 1'b0;
    unit_lat = 3;
    exp_q.push_back('{1'b0, 32'd5, 32'd5});
    exp_q.push_back('{1'b1, 32'd100, 32'd7});
    @(posedge clock); #1;
    req_a = 1'b1; op_a = ALU_MULT; a_in_a = 32'd5;   b_in_a = 32'd5;
    req_b = 1'b1; op_b = ALU_DIV;  a_in_b = 32'd100; b_in_b = 32'd7;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (stall) stall_cnt++;
      if (mif.md_start && mif.md_ready) coinc = 1'b1;
      if (done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || !coinc || stall_cnt != 7)
      $display("FAIL both_timing: got done=%0b b_start_on_ready=%0b stall_cycles=%0d, required 1/1/7",
               seen, coinc, stall_cnt);
    else passes++;
    checks++;
    if (result_a !== 32'd25 || result_b !== 32'd14 || exc_a !== 1'b0 || exc_b !== 1'b0)
      $display("FAIL both_result: got %0d/%0d exc=%0b%0b, required 25/14 exc=00",
               result_a, result_b, exc_a, exc_b);
    else passes++;
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    checks++;
    if (done !== 1'b0)
      $display("FAIL both_single_done: got done=%0b, required 0", done);
    else passes++;
  endtask

  task automatic test_b_only();
    bit seen = 1'b0;
    unit_lat = 2;
    exp_q.push_back('{1'b1, 32'd9, 32'd0});
    @(posedge clock); #1;
    a_in_a = 32'hdead; b_in_a = 32'hbeef;
    req_b = 1'b1; op_b = ALU_DIV; a_in_b = 32'd9; b_in_b = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || exc_b !== 1'b1 || result_b !== '0)
      $display("FAIL b_only_exc: got done=%0b exc_b=%0b result_b=%0d, required 1/1/0", seen, exc_b, result_b);
    else passes++;
    checks++;
    if (exc_a !== 1'b0 || result_a !== 32'd25)
      $display("FAIL b_only_a_kept: got exc_a=%0b result_a=%0d, required 0/25", exc_a, result_a);
    else passes++;
    @(posedge clock); #1;
    idle_inputs();
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    unit_lat = 5;
    exp_q.push_back('{1'b0, 32'd3, 32'd4});
    @(posedge clock); #1;
    req_a = 1'b1; op_a = ALU_MULT; a_in_a = 32'd3; b_in_a = 32'd4;
    @(negedge clock);
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    checks++;
    if (mif.md_abort !== 1'b1)
      $display("FAIL flush_abort: got md_abort=%0b, required 1", mif.md_abort);
    else passes++;
    @(posedge clock); #1;
    flush = 1'b0; req_a = 1'b0;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || mif.md_abort !== 1'b0 || done !== 1'b0)
      $display("FAIL flush_idle: got stall=%0b abort=%0b done=%0b, required 000", stall, mif.md_abort, done);
    else passes++;
    // Flush in IDLE masks a new request.
    @(posedge clock); #1;
    req_a = 1'b1; flush = 1'b1;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || mif.md_start !== 1'b0)
      $display("FAIL flush_mask: got stall=%0b start=%0b, required 0/0", stall, mif.md_start);
    else passes++;
    @(posedge clock); #1;
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen || result_a !== 32'd25 || exc_a !== 1'b0)
      $display("FAIL flush_no_write: got done_seen=%0b result_a=%0d exc_a=%0b, required 0/25/0",
               seen, result_a, exc_a);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    unit_lat = 3;
    exp_q.push_back('{1'b0, 32'd2, 32'd3});
    exp_q.push_back('{1'b0, 32'd4, 32'd5});
    @(posedge clock); #1;
    req_a = 1'b1; op_a = ALU_MULT; a_in_a = 32'd2; b_in_a = 32'd3;
    req_b = 1'b1; op_b = 5'b11111; a_in_b = 32'd4; b_in_b = 32'd5;
    repeat (5) @(negedge clock);
    checks++;
    if (result_a !== 32'd6 || stall !== 1'b1)
      $display("FAIL reset_mid_pre: got result_a=%0d stall=%0b, required 6/1", result_a, stall);
    else passes++;
    #1;
    reset_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    #1;
    checks++;
    if (result_a !== '0 || result_b !== '0 || stall !== 1'b0 || done !== 1'b0 ||
        mif.md_abort !== 1'b0 || mif.md_start !== 1'b0)
      $display("FAIL reset_mid_async: got ra=%0d rb=%0d stall=%0b done=%0b abort=%0b start=%0b, required all 0",
               result_a, result_b, stall, done, mif.md_abort, mif.md_start);
    else passes++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen || result_b !== '0 || exc_b !== 1'b0)
      $display("FAIL reset_mid_late_ready: got done_seen=%0b result_b=%0d exc_b=%0b, required 0/0/0",
               seen, result_b, exc_b);
    else passes++;
    idle_inputs();
  endtask

`ifdef MD_WATCHDOG_EN
  task automatic test_watchdog();
    int abort_at = -1;
    int done_at  = -1;
    unit_hang = 1'b1;
    exp_q.push_back('{1'b0, 32'd11, 32'd13});
    @(posedge clock); #1;
    req_a = 1'b1; op_a = ALU_MULT; a_in_a = 32'd11; b_in_a = 32'd13;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mif.md_abort && abort_at < 0) abort_at = i;
      if (done) begin done_at = i; break; end
    end
    checks++;
    if (abort_at != 8 || done_at != 9)
      $display("FAIL watchdog_timing: got abort_at=%0d done_at=%0d, required 8/9", abort_at, done_at);
    else passes++;
    checks++;
    if (result_a !== '0 || exc_a !== 1'b1)
      $display("FAIL watchdog_result: got %0d exc=%0b, required 0 exc=1", result_a, exc_a);
    else passes++;
    @(posedge clock); #1;
    idle_inputs();
    unit_hang = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_a_only();
    test_both();
    test_b_only();
    test_flush();
    test_reset_mid();
`ifdef MD_WATCHDOG_EN
    test_watchdog();
`endif
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL start_missing: got %0d unissued commands, required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
